sub_serial_32: RTL and testbench

- Multi-cycle serial subtractor for the cpu datapath; the inverse operation of the team's 32-bit ripple-carry adder.
- Computes d = a - b - bin, STEP bits per clock, LSB first, behind a valid/ready handshake on both sides.
- Used where area matters more than latency, e.g. a compare/branch unit or divider step. Its outputs can be cross-checked against the adder via a + ~b + ~bin.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/sub_chunk.sv | 25 ++
 rtl/sub_serial_32.sv | 122 ++++++++++++
 tb/tb_sub_serial_32.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: sequencer state encoding and default datapath width.
package cpu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } sub_state_t;

endpackage

// File: rtl/sub_chunk.sv
// STEP-bit combinational ripple subtractor built from full-subtractor cells.
// Latency: combinational. Backpressure: none.
module sub_chunk #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] x,
  input  logic [STEP-1:0] y,
  input  logic            bi,
  output logic [STEP-1:0] diff,
  output logic            bo
);

  logic brw;

  always_comb begin
    diff = '0;
    brw  = bi;
    for (int i = 0; i < STEP; i++) begin
      diff[i] = x[i] ^ y[i] ^ brw;
      brw     = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw);
    end
    bo = brw;
  end

endmodule

// File: rtl/sub_serial_32.sv
// Serial subtractor d = a - b - bin, STEP bits per cycle LSB first; out_valid WIDTH/STEP+1 edges after accept.
// Result and flags are held in DONE until out_ready; in_ready is low in RUN and DONE.
module sub_serial_32
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  if (STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_step
    $fatal(1, "sub_serial_32: STEP must be >= 1 and divide WIDTH");
  end

  localparam int NCHUNK = WIDTH / STEP;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  sub_state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, res_nxt;
  logic [CW-1:0]    count;
  logic             borrow, a_msb, b_msb;
  logic [STEP-1:0]  chunk_diff;
  logic             chunk_bo;

  sub_chunk #(.STEP(STEP)) u_chunk (
    .x    (a_sr[STEP-1:0]),
    .y    (b_sr[STEP-1:0]),
    .bi   (borrow),
    .diff (chunk_diff),
    .bo   (chunk_bo)
  );

  // d doubles as the result shift register: chunks enter at the MSB end so
  // the first (least significant) chunk lands at bit 0 after NCHUNK shifts.
  if (STEP == WIDTH) begin : g_res_full
    assign res_nxt = chunk_diff;
  end else begin : g_res_shift
    assign res_nxt = {chunk_diff, d[WIDTH-1:STEP]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (count == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d      <= '0;
      count  <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            count  <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> STEP;
          b_sr   <= b_sr >> STEP;
          d      <= res_nxt;
          borrow <= chunk_bo;
          count  <= count + CW'(1);
          if (count == LAST) begin
            bout <= chunk_bo;
            ovf  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
            zero <= (res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_32.sv
// Bench for sub_serial_32 at STEP=1, 4 and 32 against an arithmetic reference model.
module tb_sub_serial_32;

  localparam int STEPS [3] = '{1, 4, 32};
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic        clk, rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] a         [3];
  logic [31:0] b         [3];
  logic        bin       [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] d         [3];
  logic        bout      [3];
  logic        ovf       [3];
  logic        zero      [3];

  int checks = 0;
  int errors = 0;

  sub_serial_32 #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .bin(bin[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .d(d[0]), .bout(bout[0]), .ovf(ovf[0]), .zero(zero[0])
  );

  sub_serial_32 #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .bin(bin[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .d(d[1]), .bout(bout[1]), .ovf(ovf[1]), .zero(zero[1])
  );

  sub_serial_32 #(.WIDTH(32), .STEP(32)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .bin(bin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .d(d[2]), .bout(bout[2]), .ovf(ovf[2]), .zero(zero[2])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present operands and return #1 after the accepting edge.
  task automatic issue(input int k, input logic [31:0] ta, input logic [31:0] tb2, input logic tbin);
    int guard;
    @(negedge clk);
    a[k] = ta; b[k] = tb2; bin[k] = tbin; in_valid[k] = 1'b1;
    guard = 0;
    while (!in_ready[k] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 64'(in_ready[k]), 64'(1));
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    a[k] = $urandom; b[k] = $urandom; bin[k] = 1'($urandom);
  endtask

  // Waits for the result of an issued op, compares with the model, optionally
  // stalls out_ready for 'stall' cycles, then completes the handshake.
  task automatic expect_result(input int k, input logic [31:0] ta, input logic [31:0] tb2,
                               input logic tbin, input int stall);
    logic [32:0] full;
    longint      sd;
    logic        e_ovf;
    int          lat;
    full  = {1'b0, ta} - {1'b0, tb2} - 33'(tbin);
    sd    = longint'($signed(ta)) - longint'($signed(tb2)) - longint'(tbin);
    e_ovf = (sd > SMAX) || (sd < SMIN);
    out_ready[k] = (stall == 0);
    // The accepting edge counts as edge 1.
    lat = 1;
    @(negedge clk);
    while (!out_valid[k] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(32 / STEPS[k] + 1));
    check("d",    64'(d[k]),    64'(full[31:0]));
    check("bout", 64'(bout[k]), 64'(full[32]));
    check("ovf",  64'(ovf[k]),  64'(e_ovf));
    check("zero", 64'(zero[k]), 64'(full[31:0] == 32'd0));
    check("busy_in_ready", 64'(in_ready[k]), 64'(0));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid",    64'(out_valid[k]), 64'(1));
      check("hold_d",        64'(d[k]),         64'(full[31:0]));
      check("hold_bout",     64'(bout[k]),      64'(full[32]));
      check("hold_ovf",      64'(ovf[k]),       64'(e_ovf));
      check("hold_in_ready", 64'(in_ready[k]),  64'(0));
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    check("drop_valid",    64'(out_valid[k]), 64'(0));
    check("idle_in_ready", 64'(in_ready[k]),  64'(1));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rbin;
    int          stall;
    clk = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; a[k] = '0; b[k] = '0; bin[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready",  64'(in_ready[k]),  64'(1));
      check("rst_out_valid", 64'(out_valid[k]), 64'(0));
      check("rst_d",         64'(d[k]),         64'(0));
      check("rst_bout",      64'(bout[k]),      64'(0));
      check("rst_ovf",       64'(ovf[k]),       64'(0));
      check("rst_zero",      64'(zero[k]),      64'(0));
    end
    rst = 1'b0;

    issue(0, 32'd10, 32'd3, 1'b0);                 expect_result(0, 32'd10, 32'd3, 1'b0, 0);
    issue(0, 32'd0, 32'd1, 1'b0);                  expect_result(0, 32'd0, 32'd1, 1'b0, 0);
    issue(0, 32'd5, 32'd5, 1'b1);                  expect_result(0, 32'd5, 32'd5, 1'b1, 0);
    issue(0, 32'h8000_0000, 32'd1, 1'b0);          expect_result(0, 32'h8000_0000, 32'd1, 1'b0, 0);
    issue(0, 32'h1234, 32'h1234, 1'b0);            expect_result(0, 32'h1234, 32'h1234, 1'b0, 0);

    // Backpressure with a second request held from RUN onwards.
    issue(0, 32'hDEAD_0000, 32'h00BE_EF00, 1'b1);
    a[0] = 32'h50; b[0] = 32'h20; bin[0] = 1'b0; in_valid[0] = 1'b1;
    expect_result(0, 32'hDEAD_0000, 32'h00BE_EF00, 1'b1, 20);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    expect_result(0, 32'h50, 32'h20, 1'b0, 0);

    // Asynchronous abort in the middle of RUN.
    issue(0, 32'd100, 32'd1, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_ready",  64'(in_ready[0]),  64'(1));
    check("abort_out_valid", 64'(out_valid[0]), 64'(0));
    check("abort_d",         64'(d[0]),         64'(0));
    check("abort_bout",      64'(bout[0]),      64'(0));
    @(negedge clk);
    rst = 1'b0;
    issue(0, 32'd9, 32'd4, 1'b0);                  expect_result(0, 32'd9, 32'd4, 1'b0, 0);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 700; n++) begin
        ra   = pick();
        rb   = ($urandom_range(0, 9) == 0) ? ra : pick();
        rbin = 1'($urandom);
        stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
        issue(k, ra, rb, rbin);
        expect_result(k, ra, rb, rbin, stall);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
